// File: rtl/rx_os_lane_tracker.sv
// Rx ordered-set tracker: per-lane consecutive TS1/TS2 match counting with completion flag.
// Optional training timeout is built only when RX_OS_TIMEOUT_EN is defined.
module rx_os_lane_tracker #(
  parameter int LANES   = 16,
  parameter int CNT_W   = 5,
  parameter int TIMER_W = 24
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_os_type_sel,
  input  logic                   i_check_link,
  input  logic [7:0]             i_link_number,
  input  logic                   i_check_lane,
  input  logic [CNT_W-1:0]       i_threshold,
  input  logic [5:0]             i_active_lanes,
  input  logic [TIMER_W-1:0]     i_timeout_cycles,
  input  logic [LANES*128-1:0]   i_os_data,
  input  logic [LANES-1:0]       i_os_valid,
  output logic [LANES-1:0]       o_lane_done,
  output logic                   o_all_done,
  output logic                   o_timed_out,
  output logic                   o_busy,
  output logic [7:0]             o_rate_id
);

  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_DONE, ST_TIMEOUT} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_rate_id;
  logic [7:0]         w_id;
  logic [6:0]         w_eff_lanes;
  logic [LANES-1:0]   w_active;
  logic [LANES-1:0]   w_lane_match;
  logic [LANES-1:0]   w_lane_done;
  logic               w_complete;
  logic               w_timeout_hit;
  logic               w_tracking;
  logic               w_unused_os;

  assign w_id        = i_os_type_sel ? 8'h45 : 8'h4A;
  assign w_tracking  = (r_state == ST_TRACK);
  assign w_eff_lanes = ({1'b0, i_active_lanes} > 7'(LANES)) ? 7'(LANES) : {1'b0, i_active_lanes};
  // Only byte4 of lane 0 feeds an output; other payload bytes are don't-care.
  assign w_unused_os = ^i_os_data;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [127:0]     w_os;
      logic             w_id_ok;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
      logic             r_done;

      assign w_os         = i_os_data[128*gi +: 128];
      assign w_active[gi] = (7'(gi) < w_eff_lanes);

      always_comb begin
        w_id_ok = 1'b1;
        for (int k = 6; k < 16; k++) begin
          if (w_os[8*k +: 8] != w_id) w_id_ok = 1'b0;
        end
      end

      assign w_lane_match[gi] = (w_os[7:0] == 8'hBC) && w_id_ok &&
                                (!i_check_link || (w_os[15:8] == i_link_number)) &&
                                (!i_check_lane || (w_os[23:16] == 8'(gi)));

      always_comb begin
        w_cnt_next = r_cnt;
        if (!w_active[gi]) begin
          w_cnt_next = '0;
        end else if (i_os_valid[gi]) begin
          if (!w_lane_match[gi]) w_cnt_next = '0;
          else if (!(&r_cnt))    w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          r_cnt  <= '0;
          r_done <= 1'b0;
        end else if (i_start) begin
          r_cnt  <= '0;
          r_done <= w_active[gi] && (i_threshold == '0);
        end else if (w_tracking) begin
          r_cnt  <= w_cnt_next;
          r_done <= w_active[gi] && (w_cnt_next >= i_threshold);
        end
      end

      assign w_lane_done[gi] = r_done;
    end
  endgenerate

  // Inactive lanes count as satisfied so an empty lane set completes at once.
  assign w_complete  = &(w_lane_done | ~w_active);
  assign o_lane_done = w_lane_done;
  assign o_rate_id   = r_rate_id;

`ifdef RX_OS_TIMEOUT_EN
  logic [TIMER_W-1:0] r_timer;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)        r_timer <= '0;
    else if (i_start)    r_timer <= '0;
    else if (w_tracking) r_timer <= r_timer + TIMER_W'(1);
  end

  assign w_timeout_hit = (i_timeout_cycles != '0) &&
                         (r_timer == i_timeout_cycles - TIMER_W'(1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^i_timeout_cycles;
  assign w_timeout_hit    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_start) begin
      w_state_next = ST_TRACK;
    end else if (w_tracking) begin
      if (w_complete)         w_state_next = ST_DONE;
      else if (w_timeout_hit) w_state_next = ST_TIMEOUT;
    end
  end

  always_comb begin
    o_busy      = 1'b0;
    o_all_done  = 1'b0;
    o_timed_out = 1'b0;
    case (r_state)
      ST_TRACK: o_busy     = 1'b1;
      ST_DONE:  o_all_done = 1'b1;
`ifdef RX_OS_TIMEOUT_EN
      ST_TIMEOUT: o_timed_out = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rate_id <= 8'h00;
    end else if (!i_start && w_tracking && i_os_valid[0] && w_lane_match[0]) begin
      r_rate_id <= i_os_data[39:32];
    end
  end

endmodule

// File: tb/tb_rx_os_lane_tracker.sv
// Scoreboard bench for rx_os_lane_tracker: directed test-plan scenarios plus randomized traffic.
module tb_rx_os_lane_tracker;

  localparam int LANES   = 16;
  localparam int CNT_W   = 5;
  localparam int TIMER_W = 24;
  localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef RX_OS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 sel = 1'b0;
  logic                 chk_link = 1'b0;
  logic [7:0]           link_num = 8'h00;
  logic                 chk_lane = 1'b0;
  logic [CNT_W-1:0]     thr = '0;
  logic [5:0]           act = '0;
  logic [TIMER_W-1:0]   tc = '0;
  logic [LANES*128-1:0] os_data;
  logic [LANES-1:0]     valid = '0;
  logic [7:0]           b [LANES][16];

  logic [LANES-1:0]     o_lane_done;
  logic                 o_all_done, o_timed_out, o_busy;
  logic [7:0]           o_rate_id;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [LANES-1:0] ld;
    logic             ad;
    logic             to;
    logic             by;
    logic [7:0]       rate;
  } exp_t;
  exp_t q[$];

  // Reference model state
  int         m_cnt [LANES];
  bit         m_ld  [LANES];
  bit         m_track, m_done, m_to;
  int         m_timer;
  logic [7:0] m_rate;

  always #5 clk = ~clk;

  always_comb begin
    os_data = '0;
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < 16; k++)
        os_data[128*i + 8*k +: 8] = b[i][k];
  end

  rx_os_lane_tracker #(.LANES(LANES), .CNT_W(CNT_W), .TIMER_W(TIMER_W)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_os_type_sel(sel),
    .i_check_link(chk_link), .i_link_number(link_num), .i_check_lane(chk_lane),
    .i_threshold(thr), .i_active_lanes(act), .i_timeout_cycles(tc),
    .i_os_data(os_data), .i_os_valid(valid), .o_lane_done(o_lane_done),
    .o_all_done(o_all_done), .o_timed_out(o_timed_out), .o_busy(o_busy),
    .o_rate_id(o_rate_id)
  );

  task automatic chk(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit lane_ok(int i);
    logic [7:0] id = sel ? 8'h45 : 8'h4A;
    if (b[i][0] != 8'hBC) return 1'b0;
    for (int k = 6; k < 16; k++) if (b[i][k] != id) return 1'b0;
    if (chk_link && b[i][1] != link_num) return 1'b0;
    if (chk_lane && b[i][2] != 8'(i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LANES; i++) begin m_cnt[i] = 0; m_ld[i] = 1'b0; end
    m_track = 0; m_done = 0; m_to = 0; m_timer = 0; m_rate = 8'h00;
  endfunction

  function automatic void model_edge();
    int eff;
    bit complete, hit;
    if (!rst_n) begin model_clear(); return; end
    eff = (int'(act) > LANES) ? LANES : int'(act);
    if (start) begin
      m_track = 1; m_done = 0; m_to = 0; m_timer = 0;
      for (int i = 0; i < LANES; i++) begin
        m_cnt[i] = 0;
        m_ld[i]  = (i < eff) && (thr == 0);
      end
    end else if (m_track) begin
      complete = 1;
      for (int i = 0; i < eff; i++) if (!m_ld[i]) complete = 0;
      hit = TO_EN && (tc != 0) && (m_timer == int'(tc) - 1);
      for (int i = 0; i < LANES; i++) begin
        if (i >= eff) m_cnt[i] = 0;
        else if (valid[i]) m_cnt[i] = lane_ok(i) ? ((m_cnt[i] >= CMAX) ? CMAX : m_cnt[i] + 1) : 0;
        m_ld[i] = (i < eff) && (m_cnt[i] >= int'(thr));
      end
      if (valid[0] && lane_ok(0)) m_rate = b[0][4];
      m_timer++;
      if (complete) begin m_track = 0; m_done = 1; end
      else if (hit) begin m_track = 0; m_to = 1; end
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    for (int i = 0; i < LANES; i++) e.ld[i] = m_ld[i];
    e.ad = m_done; e.to = m_to; e.by = m_track; e.rate = m_rate;
    q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    push_exp();
    @(negedge clk);
  endtask

  function automatic void fill_good(int i, logic [7:0] rate);
    logic [7:0] id = sel ? 8'h45 : 8'h4A;
    b[i][0] = 8'hBC; b[i][1] = link_num; b[i][2] = 8'(i);
    b[i][3] = 8'($urandom_range(0, 255)); b[i][4] = rate; b[i][5] = 8'($urandom_range(0, 255));
    for (int k = 6; k < 16; k++) b[i][k] = id;
  endfunction

  function automatic void all_good(logic [7:0] rate0);
    fill_good(0, rate0);
    for (int i = 1; i < LANES; i++) fill_good(i, 8'($urandom_range(0, 255)));
  endfunction

  function automatic void corrupt(int i);
    int k;
    k = $urandom_range(0, 14);
    k = (k < 4) ? ((k == 3) ? 4 : k) : k + 1;
    b[i][k] = b[i][k] ^ 8'($urandom_range(1, 255));
  endfunction

  task automatic cfg(int a, int t, bit s, bit cl, logic [7:0] ln, bit cn, int tmo);
    act = 6'(a); thr = CNT_W'(t); sel = s; chk_link = cl; link_num = ln; chk_lane = cn;
    tc = TIMER_W'(tmo); valid = '0;
  endtask

  task automatic do_start();
    start = 1'b1; valid = '0;
    step();
    start = 1'b0;
  endtask

  // Monitor: pop one expected snapshot per presented output sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("lane_done", 32'(o_lane_done), 32'(e.ld));
        chk("all_done",  32'(o_all_done),  32'(e.ad));
        chk("timed_out", 32'(o_timed_out), 32'(e.to));
        chk("busy",      32'(o_busy),      32'(e.by));
        chk("rate_id",   32'(o_rate_id),   32'(e.rate));
      end
    end
  end

  initial begin
    int len;
    model_clear();
    for (int i = 0; i < LANES; i++) for (int k = 0; k < 16; k++) b[i][k] = 8'h00;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_lane_done", 32'(o_lane_done), 0);

    // S1: four lanes of TS1, threshold 8
    $display("scenario 1: 4 lanes TS1 threshold 8");
    cfg(4, 8, 0, 1, 8'h03, 1, 0);
    do_start();
    chk("s1_busy", 32'(o_busy), 1);
    for (int n = 1; n <= 9; n++) begin
      all_good(8'h06);
      valid = (n <= 8) ? 16'h000F : 16'h0000;
      step();
      if (n == 7) chk("s1_ld_n7", 32'(o_lane_done), 0);
      if (n == 8) begin
        chk("s1_ld_n8", 32'(o_lane_done), 32'h000F);
        chk("s1_ad_n8", 32'(o_all_done), 0);
      end
      if (n == 9) begin
        chk("s1_ad_n9", 32'(o_all_done), 1);
        chk("s1_busy_n9", 32'(o_busy), 0);
      end
    end

    // S2: lane 2 sends TS2 after five good TS1s
    $display("scenario 2: lane 2 TS2 interruption");
    cfg(4, 8, 0, 0, 8'h00, 0, 0);
    do_start();
    for (int n = 1; n <= 15; n++) begin
      all_good(8'h11);
      if (n == 6) for (int k = 6; k < 16; k++) b[2][k] = 8'h45;
      valid = 16'h000F;
      step();
      if (n == 8)  chk("s2_ld_n8", 32'(o_lane_done), 32'h000B);
      if (n == 14) chk("s2_ad_n14", 32'(o_all_done), 0);
      if (n == 15) chk("s2_ad_n15", 32'(o_all_done), 1);
    end

    // S3: lane 1 carries the wrong link number; timeout 100
    $display("scenario 3: bad link on lane 1, timeout 100");
    cfg(4, 8, 0, 1, 8'h03, 0, 100);
    do_start();
    for (int n = 1; n <= 100; n++) begin
      all_good(8'h22);
      b[1][1] = 8'h07;
      valid = 16'h000F;
      step();
      if (n == 99) chk("s3_to_n99", 32'(o_timed_out), 0);
      if (n == 100) begin
        chk("s3_to_n100", 32'(o_timed_out), 32'(TO_EN));
        chk("s3_busy_n100", 32'(o_busy), 32'(!TO_EN));
        chk("s3_ld_n100", 32'(o_lane_done), 32'h000D);
      end
    end

    // S4: completion and timeout land on the same edge
    $display("scenario 4: completion coincides with timeout");
    cfg(4, 8, 1, 0, 8'h00, 1, 9);
    do_start();
    for (int n = 1; n <= 9; n++) begin
      all_good(8'h33);
      valid = (n <= 8) ? 16'h000F : 16'h0000;
      step();
    end
    chk("s4_ad", 32'(o_all_done), 1);
    chk("s4_to", 32'(o_timed_out), 0);

    // S5: saturation at threshold 31, lane 3 never matches
    $display("scenario 5: threshold 31 saturation");
    cfg(4, 31, 0, 0, 8'h00, 0, 0);
    do_start();
    for (int n = 1; n <= 40; n++) begin
      all_good(8'h06);
      b[3][0] = 8'h00;
      valid = 16'h000F;
      step();
      if (n == 30) chk("s5_ld_n30", 32'(o_lane_done), 0);
      if (n == 31) chk("s5_ld_n31", 32'(o_lane_done), 32'h0007);
    end
    chk("s5_ld_n40", 32'(o_lane_done), 32'h0007);
    chk("s5_rate", 32'(o_rate_id), 32'h06);

    // S6: asynchronous reset mid-TRACK, then a fresh run
    $display("scenario 6: reset mid-track then restart");
    cfg(4, 8, 0, 0, 8'h00, 0, 0);
    do_start();
    for (int n = 1; n <= 4; n++) begin all_good(8'h44); valid = 16'h000F; step(); end
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("s6_rst_busy", 32'(o_busy), 0);
    chk("s6_rst_ld", 32'(o_lane_done), 0);
    chk("s6_rst_rate", 32'(o_rate_id), 0);
    step();
    rst_n = 1'b1;
    do_start();
    for (int n = 1; n <= 9; n++) begin
      all_good(8'h55);
      valid = (n <= 8) ? 16'h000F : 16'h0000;
      step();
      if (n == 7) chk("s6_ld_n7", 32'(o_lane_done), 0);
      if (n == 8) chk("s6_ld_n8", 32'(o_lane_done), 32'h000F);
      if (n == 9) chk("s6_ad_n9", 32'(o_all_done), 1);
    end

    // Randomized traffic
    for (int s = 0; s < 40; s++) begin
      cfg($urandom_range(0, 20), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60));
      $display("scenario r%0d: act=%0d thr=%0d tc=%0d", s, act, thr, tc);
      do_start();
      len = $urandom_range(10, 60);
      for (int c = 0; c < len; c++) begin
        for (int i = 0; i < LANES; i++) begin
          fill_good(i, 8'($urandom_range(0, 255)));
          if ($urandom_range(0, 9) == 0) corrupt(i);
        end
        valid = LANES'($urandom);
        start = ($urandom_range(0, 39) == 0);
        step();
      end
      start = 1'b0;
    end

    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_os_lane_tracker.md
# rx_os_lane_tracker

Parametrised receive-side ordered-set tracker for the Rx LTSSM. It counts consecutive matching TS1/TS2 ordered sets on each of up to `LANES` lanes, checks link and lane numbers, and flags completion when every active lane reaches a programmable threshold. It also raises a programmable training timeout. The master Rx state machine uses it in Polling/Configuration substates in place of fixed 16-lane checker/counter/comparator slices plus a separate timer.

## Interface
- `LANES`, 16, number of lane slices (1..32)
- `CNT_W`, 5, width of per-lane consecutive-match counter and threshold
- `TIMER_W`, 24, width of timeout counter and `timeout_cycles`
- `clk` in 1, sole clock, all state on rising edge
- `reset` in 1, asynchronous, active-low
- `start` in 1, arm/re-arm pulse; clears counts and timer, samples nothing else
- `os_type_sel` in 1, 0 = expect TS1 (ID 8'h4A), 1 = expect TS2 (ID 8'h45)
- `check_link` in 1, require byte1 == `link_number`
- `link_number` in 8, expected link number
- `check_lane` in 1, require byte2 == lane index
- `threshold` in CNT_W, consecutive matches required per lane
- `active_lanes` in 6, lanes 0..active_lanes-1 participate; values > LANES clamp to LANES
- `timeout_cycles` in TIMER_W, timeout length in clk cycles; 0 = no timeout
- `os_data` in LANES*128, lane i ordered set at [128i+127:128i], byte k at [8k+7:8k]
- `os_valid` in LANES, per-lane strobe, one ordered set per asserted cycle
- `lane_done` out LANES, registered, lane count ≥ threshold
- `all_done` out 1, registered level, high in DONE
- `timed_out` out 1, registered level, high in TIMEOUT
- `busy` out 1, high in TRACK
- `rate_id` out 8, byte4 of last matching lane-0 ordered set

## Operation
- States: IDLE, TRACK, DONE, TIMEOUT. Reset → IDLE, all outputs 0, counts 0, timer 0.
- `start` high in any state → TRACK next edge; counts and timer cleared; `rate_id` kept.
- Match (lane i): byte0 == 8'hBC; bytes 6..15 all equal selected ID; plus link/lane checks when enabled.
- TRACK, active lane, `os_valid[i]`: match → count+1, saturating at 2^CNT_W-1; mismatch → count 0. No valid → hold.
- Inactive lanes: count forced to 0, `lane_done` 0, ignored for completion.
- `lane_done[i]` = active and count ≥ threshold, registered from the updated count.
- TRACK → DONE when all active `lane_done` are set; with threshold 0 or active_lanes 0, the transition occurs on the first TRACK edge.
- TRACK → TIMEOUT when timer reaches `timeout_cycles`-1 and completion is not met. Completion and timeout on the same edge → DONE.
- DONE/TIMEOUT hold until `start`; `os_valid` ignored, counts frozen, `lane_done` held.
- `rate_id` updates only on a matching lane-0 ordered set in TRACK.
- Inputs other than `start`, `os_*` are read live each cycle; must be stable during TRACK.

## Timing
- `start` sampled at edge E0 → `busy` = 1 after E0.
- Valid ordered set at edge En → count and `lane_done` updated after En. `all_done` is set after En+1 (2-cycle latency from the final ordered set).
- Timer = 0 after E0, +1 per TRACK edge; `timed_out` set after edge E0+timeout_cycles.
- Asynchronous reset mid-TRACK → immediate IDLE, all outputs 0.

## Configuration
- `RX_OS_TIMEOUT_EN` defined: timer, `timeout_cycles`, and TIMEOUT state are present as specified above.
- Undefined: timer removed, `timeout_cycles` ignored, `timed_out` tied 0, TIMEOUT unreachable, TRACK exits only via completion or `start`.

## Test plan
- LANES=16, active_lanes=4, threshold=8, TS1, valid TS1 on lanes 0-3 every cycle → `lane_done[3:0]`=4'hF after 8th set, `all_done` one cycle later, `lane_done[15:4]`=0.
- Lane 2 sends a TS2 after 5 good TS1s → lane 2 count = 0; `all_done` rises only after lane 2 completes 8 more consecutive TS1s.
- check_link=1, link_number=8'h03, lane 1 byte1=8'h07 → lane 1 never completes; with timeout_cycles=100, `timed_out`=1 exactly 100 edges after start, `busy`=0.
- Completion and timeout on the same edge → `all_done`=1, `timed_out`=0.
- threshold=31, CNT_W=5, 40 matches → count saturates at 31 and `lane_done` stays 1; `rate_id` = 8'h06 from lane-0 byte4.
- Assert `reset`=0 mid-TRACK, then `start` again → all outputs 0, then fresh count from 0 with identical latency.
